rom_access_arbiter: RTL

Shares the single combinational instruction ROM between two requesters: port 0 is IF-stage fetch and port 1 is MEM-stage loads from the text segment. Each port has a valid/ready request channel and a valid/ready response channel. Responses are registered, one per port. Port 1 has fixed priority, bounded by a starvation guard for port 0. Port 0 supports flush on branch redirect.

---
 rtl/rom_arb_pkg.sv | 25 ++
 rtl/rom_resp_slot.sv | 38 +++
 rtl/rom_access_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared constants and address helper for the instruction-ROM arbiter.
package rom_arb_pkg;

  localparam int PORT_IF        = 0;  // IF-stage fetch
  localparam int PORT_MEM       = 1;  // MEM-stage loads from .text
  localparam int MAX_CONSEC_DEF = 4;

  typedef struct packed {
    logic [31:0] idx;  // word index, already masked to the ROM width
    logic        oor;  // address lies beyond the ROM
  } word_idx_t;

  // Byte address -> word index plus out-of-range flag. Bits [1:0] are
  // dropped on purpose: misaligned fetches simply read the containing word.
  function automatic word_idx_t byte_to_word(input logic [63:0] addr,
                                             input int rom_bits);
    word_idx_t   r;
    logic [63:0] mask;
    mask  = (64'd1 << rom_bits) - 64'd1;
    r.idx = 32'((addr >> 2) & mask);
    r.oor = (addr >> (rom_bits + 2)) != 64'd0;
    return r;
  endfunction

endpackage

// File: rtl/rom_resp_slot.sv
// One registered response slot with valid/ready hold and flush.
module rom_resp_slot #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 load_err,
  input  logic                 flush,
  input  logic                 resp_ready,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_data,
  output logic                 resp_err,
  output logic                 free
);

  // The slot can accept a new word when empty or being drained this cycle.
  assign free = !resp_valid || resp_ready;

  // Flush beats a concurrent consume; a load refills back-to-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else if (load) begin
      resp_valid <= 1'b1;
      resp_data  <= load_data;
      resp_err   <= load_err;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Two-port arbiter in front of a combinational instruction ROM.
// Port 1 (MEM) has fixed priority; a consecutive-grant counter guarantees
// port 0 (IF) a turn after MAX_CONSEC port-1 wins while it waits.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_BITS     = 32,
  parameter int ROM_ADDR_BITS = 10,
  parameter int DATA_BITS     = 32,
  parameter int MAX_CONSEC    = MAX_CONSEC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     p0_req_valid,
  input  logic [ADDR_BITS-1:0]     p0_req_addr,
  output logic                     p0_req_ready,
  output logic                     p0_resp_valid,
  output logic [DATA_BITS-1:0]     p0_resp_data,
  output logic                     p0_resp_err,
  input  logic                     p0_resp_ready,
  input  logic                     p0_flush,
  input  logic                     p1_req_valid,
  input  logic [ADDR_BITS-1:0]     p1_req_addr,
  output logic                     p1_req_ready,
  output logic                     p1_resp_valid,
  output logic [DATA_BITS-1:0]     p1_resp_data,
  output logic                     p1_resp_err,
  input  logic                     p1_resp_ready,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  output logic                     rom_sel,
  input  logic [DATA_BITS-1:0]     rom_dout
);

  localparam int CW = $clog2(MAX_CONSEC + 1);

  logic [1:0]     free, elig, grant;
  logic [CW-1:0]  consec;
  logic           starved;
  word_idx_t      w;
  logic [DATA_BITS-1:0] load_data;

  // Eligibility and grant; forcing elig low in reset keeps every
  // combinational output at 0 while rst_n is low.
  always_comb begin
    elig[PORT_MEM] = rst_n && p1_req_valid && free[PORT_MEM];
    elig[PORT_IF]  = rst_n && p0_req_valid && free[PORT_IF] && !p0_flush;
    starved        = (consec == CW'(MAX_CONSEC));
    grant[PORT_IF]  = elig[PORT_IF] && (!elig[PORT_MEM] || starved);
    grant[PORT_MEM] = elig[PORT_MEM] && !grant[PORT_IF];
  end

  assign p0_req_ready = grant[PORT_IF];
  assign p1_req_ready = grant[PORT_MEM];

  // ROM drive from the granted port; out-of-range reads return zero.
  always_comb begin
    w = byte_to_word(64'(grant[PORT_MEM] ? p1_req_addr : p0_req_addr),
                     ROM_ADDR_BITS);
    rom_sel   = |grant;
    rom_addr  = rom_sel ? w.idx[ROM_ADDR_BITS-1:0] : '0;
    load_data = w.oor ? '0 : rom_dout;
  end

  // Count port-1 wins while port 0 is waiting; saturate at MAX_CONSEC.
  always_ff @(posedge clk) begin
    if (!rst_n)
      consec <= '0;
    else if (grant[PORT_IF] || !elig[PORT_IF])
      consec <= '0;
    else if (grant[PORT_MEM] && !starved)
      consec <= consec + CW'(1);
  end

  rom_resp_slot #(.DATA_BITS(DATA_BITS)) u_slot_if (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant[PORT_IF]),
    .load_data  (load_data),
    .load_err   (w.oor),
    .flush      (p0_flush),
    .resp_ready (p0_resp_ready),
    .resp_valid (p0_resp_valid),
    .resp_data  (p0_resp_data),
    .resp_err   (p0_resp_err),
    .free       (free[PORT_IF])
  );

  rom_resp_slot #(.DATA_BITS(DATA_BITS)) u_slot_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (grant[PORT_MEM]),
    .load_data  (load_data),
    .load_err   (w.oor),
    .flush      (1'b0),
    .resp_ready (p1_resp_ready),
    .resp_valid (p1_resp_valid),
    .resp_data  (p1_resp_data),
    .resp_err   (p1_resp_err),
    .free       (free[PORT_MEM])
  );

endmodule
